// File: rtl/apb_host_master.sv
// apb_host_master: host command/response front end driving a single APB requester with access timeout
module apb_host_master #(
   parameter int ADDR_W  = 9,
   parameter int DATA_W  = 91,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic [ADDR_W-1:0] paddr,
   output logic              pwrite,
   output logic              psel,
   output logic              penable,
   output logic [DATA_W-1:0] pwdata,
   input  logic [DATA_W-1:0] prdata,
   input  logic              pready,
   output logic              busy,
   output logic [7:0]        err_count
);
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [1:0] IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2, RESP = 2'd3;

   logic [1:0]        state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_inc;
   logic              timeout_hit, acc_done;
   logic              psel_q, penable_q, pwrite_q, busy_q, rsp_valid_q, rsp_err_q;
   logic [ADDR_W-1:0] paddr_q;
   logic [DATA_W-1:0] pwdata_q, rsp_rdata_q;
   logic [7:0]        err_count_q;

   assign cnt_inc     = cnt_q + CW'(1);
   assign timeout_hit = state_q == ACCESS && !pready && cnt_inc == CW'(TIMEOUT);
   assign acc_done    = state_q == ACCESS && (pready || timeout_hit);
   assign cmd_ready   = state_q == IDLE;
   assign psel        = psel_q;
   assign penable     = penable_q;
   assign pwrite      = pwrite_q;
   assign paddr       = paddr_q;
   assign pwdata      = pwdata_q;
   assign busy        = busy_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_err     = rsp_err_q;
   assign err_count   = err_count_q;

   // next state: accept in IDLE, one SETUP cycle, ACCESS until pready or timeout, RESP until taken
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = cmd_valid ? SETUP : IDLE;
         SETUP:   state_d = ACCESS;
         ACCESS:  state_d = acc_done ? RESP : ACCESS;
         default: state_d = rsp_ready ? IDLE : RESP;
      endcase
   end

   // all APB and response outputs are registered off the next state and the sampled slave signals
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         busy_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         err_count_q <= '0;
      end else begin
         state_q   <= state_d;
         psel_q    <= state_d == SETUP || state_d == ACCESS;
         penable_q <= state_d == ACCESS;
         busy_q    <= state_d != IDLE;
         cnt_q     <= state_q == ACCESS ? cnt_inc : '0;
         if (state_q == IDLE && cmd_valid) begin
            pwrite_q <= cmd_write;
            paddr_q  <= cmd_addr;
            pwdata_q <= cmd_write ? cmd_wdata : '0;
         end
         if (acc_done) begin
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= (pready && !pwrite_q) ? prdata : '0;
            rsp_err_q   <= !pready;
            if (!pready && err_count_q != 8'hFF)
               err_count_q <= err_count_q + 8'd1;
         end else if (state_q == RESP && rsp_ready) begin
            rsp_valid_q <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_apb_host_master.sv
// tb_apb_host_master: directed and randomized APB transfers checked against a transaction-level model
module tb_apb_host_master;
   localparam int AW = 9, DW = 91, TO = 16;

   logic          clk = 1'b0, rst_n = 1'b0;
   logic          cmd_valid = 0, cmd_ready, cmd_write = 0, rsp_valid, rsp_ready = 0, rsp_err;
   logic [AW-1:0] cmd_addr = '0, paddr;
   logic [DW-1:0] cmd_wdata = '0, rsp_rdata, pwdata, prdata = '0;
   logic          pwrite, psel, penable, pready = 0, busy;
   logic [7:0]    err_count;

   int checks = 0, fails = 0, err_exp = 0, cyc = 0, last_acc_cyc = -100;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   apb_host_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .paddr(paddr), .pwrite(pwrite), .psel(psel), .penable(penable), .pwdata(pwdata),
      .prdata(prdata), .pready(pready), .busy(busy), .err_count(err_count)
   );

   function automatic logic [DW-1:0] rnd();
      return DW'({$urandom, $urandom, $urandom});
   endfunction

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One full transfer. wt = pready-low ACCESS cycles before pready goes high (>= TO means never in time).
   // nv/nw/na/nwd present the next command on the bus at the response handshake for back-to-back use.
   task automatic xfer(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] wd, input int wt,
                       input logic [DW-1:0] prd, input int hold, input bit b2b,
                       input bit nv, input bit nw, input logic [AW-1:0] na, input logic [DW-1:0] nwd);
      int n, bound;
      bit err;
      logic [DW-1:0] wexp, rexp;
      err  = (wt + 1 > TO);
      wexp = w ? wd : '0;
      rexp = (!err && !w) ? prd : '0;
      if (err) err_exp = (err_exp == 255) ? 255 : err_exp + 1;
      chk("cmd_ready_idle", cmd_ready, 1);
      cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = w ? wd : rnd();
      @(negedge clk);
      cmd_valid = nv;
      chk("setup_psel", psel, 1);
      chk("setup_penable", penable, 0);
      chk("setup_paddr", paddr, a);
      chk("setup_pwrite", pwrite, w);
      chk("setup_pwdata", pwdata, wexp);
      chk("setup_busy", busy, 1);
      chk("setup_cmd_ready", cmd_ready, 0);
      if (b2b) chk("b2b_gap", cyc - last_acc_cyc - 1, 2);
      pready = 1'($urandom); prdata = rnd();
      n = 0; bound = 0;
      @(negedge clk);
      while (psel === 1'b1 && bound < 200) begin
         bound++; n++; last_acc_cyc = cyc;
         chk("acc_penable", penable, 1);
         chk("acc_paddr", paddr, a);
         chk("acc_pwdata", pwdata, wexp);
         chk("acc_pwrite", pwrite, w);
         pready = (n == wt + 1);
         prdata = pready ? prd : rnd();
         @(negedge clk);
      end
      chk("access_cycles", n, err ? TO : wt + 1);
      chk("resp_psel", psel, 0);
      chk("resp_penable", penable, 0);
      chk("resp_valid", rsp_valid, 1);
      chk("resp_err", rsp_err, err);
      chk("resp_rdata", rsp_rdata, rexp);
      chk("err_count", err_count, err_exp);
      chk("resp_paddr_hold", paddr, a);
      chk("resp_pwdata_hold", pwdata, wexp);
      chk("resp_busy", busy, 1);
      repeat (hold) begin
         pready = 1'($urandom); prdata = rnd();
         @(negedge clk);
         chk("bp_valid", rsp_valid, 1);
         chk("bp_rdata", rsp_rdata, rexp);
         chk("bp_err", rsp_err, err);
         chk("bp_cmd_ready", cmd_ready, 0);
         chk("bp_psel", psel, 0);
      end
      rsp_ready = 1; cmd_valid = nv; cmd_write = nw; cmd_addr = na; cmd_wdata = nwd;
      @(negedge clk);
      rsp_ready = 0; pready = 0;
      chk("done_valid", rsp_valid, 0);
      chk("done_cmd_ready", cmd_ready, 1);
      chk("done_busy", busy, 0);
      chk("done_psel", psel, 0);
   endtask

   // Pulse reset while in SETUP (ph=2), ACCESS (ph=0) or RESP (ph=1) and check the transfer is dropped.
   task automatic rst_mid(input int ph);
      cmd_valid = 1; cmd_write = 1'($urandom); cmd_addr = AW'($urandom); cmd_wdata = rnd();
      @(negedge clk);
      cmd_valid = 0; pready = 0;
      if (ph != 2) begin
         @(negedge clk);
         if (ph == 1) begin
            pready = 1;
            @(negedge clk);
            pready = 0;
         end
      end
      rst_n = 0;
      #1;
      chk("rst_psel", psel, 0);
      chk("rst_penable", penable, 0);
      chk("rst_valid", rsp_valid, 0);
      chk("rst_busy", busy, 0);
      @(negedge clk);
      rst_n = 1;
      err_exp = 0;
      @(negedge clk);
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_busy_after", busy, 0);
      chk("rst_err_count", err_count, err_exp);
      @(negedge clk);
      chk("rst_no_rsp", rsp_valid, 0);
      chk("rst_no_psel", psel, 0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge clk);
      chk("reset_psel", psel, 0);
      chk("reset_penable", penable, 0);
      chk("reset_pwrite", pwrite, 0);
      chk("reset_paddr", paddr, 0);
      chk("reset_pwdata", pwdata, 0);
      chk("reset_rsp_valid", rsp_valid, 0);
      chk("reset_rsp_rdata", rsp_rdata, 0);
      chk("reset_rsp_err", rsp_err, 0);
      chk("reset_busy", busy, 0);
      chk("reset_err_count", err_count, 0);
      rst_n = 1;
      @(negedge clk);
      chk("post_reset_cmd_ready", cmd_ready, 1);
      // write, pready on the second ACCESS cycle
      xfer(1, 9'h002, 91'h5A, 1, rnd(), 0, 0, 0, 0, '0, '0);
      // read with immediate pready
      xfer(0, 9'h00C, rnd(), 0, 91'h1F, 0, 0, 0, 0, '0, '0);
      // timeout with pready never asserted
      xfer(1, 9'h1A5, rnd(), 1000, rnd(), 0, 0, 0, 0, '0, '0);
      // pready arrives exactly on the last allowed ACCESS cycle, then one cycle short of that
      xfer(0, 9'h0F0, rnd(), TO - 1, rnd(), 0, 0, 0, 0, '0, '0);
      xfer(0, 9'h0F1, rnd(), TO - 2, rnd(), 0, 0, 0, 0, '0, '0);
      // response backpressure for 5 cycles
      xfer(0, 9'h033, rnd(), 2, rnd(), 5, 0, 0, 0, '0, '0);
      // back-to-back writes with cmd_valid held high
      xfer(1, 9'h010, 91'h111, 0, rnd(), 0, 0, 1, 1, 9'h011, 91'h222);
      xfer(1, 9'h011, 91'h222, 1, rnd(), 0, 1, 0, 0, '0, '0);
      // randomized transfers
      for (int i = 0; i < 40; i++)
         xfer(1'($urandom), AW'($urandom), rnd(), int'($urandom_range(0, 20)), rnd(),
              int'($urandom_range(0, 3)), 0, 0, 0, '0, '0);
      // drive err_count into saturation and past it
      while (err_exp < 255)
         xfer(1'($urandom), AW'($urandom), rnd(), 100, rnd(), 0, 0, 0, 0, '0, '0);
      repeat (2) xfer(0, AW'($urandom), rnd(), 100, rnd(), 0, 0, 0, 0, '0, '0);
      // resets in the middle of a transfer
      rst_mid(0);
      rst_mid(1);
      rst_mid(2);
      xfer(0, 9'h155, rnd(), 3, rnd(), 1, 0, 0, 0, '0, '0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
